// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, controller state enum and the mode-register helper.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [12:0] ADDR_A10  = 13'h0400;
  localparam logic [3:0]  PEND_MAX  = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_PRE, S_PRE_W, S_REF, S_REF_W, S_LOAD, S_LOAD_W,
    S_READY, S_A_PRE, S_A_PRE_W, S_A_REF, S_A_REF_W
  } state_t;

  function automatic logic [12:0] mode_word(input logic [2:0] cas, input logic [2:0] bl,
                                            input logic wb);
    mode_word = {3'b000, wb, 2'b00, cas, 1'b0, bl};
  endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; done is high once the count has run down to zero.
module sdram_wait_timer #(
  parameter int CNT_W = 16
) (
  input  logic             iclk,
  input  logic             ctr_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset)        cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up initialiser followed by a periodic auto-refresh scheduler that
// requests the bus from the arbiter and runs PALL+REF once granted.
module sdram_init_refresh_ctrl
  import sdram_pkg::*;
#(
  parameter int T_PWRUP      = 16,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int N_INIT_REF   = 8,
  parameter int REF_INTERVAL = 780,
  parameter int CAS_LAT      = 2,
  parameter int BL_CODE      = 3,
  parameter int WB_SINGLE    = 1,
  parameter int CNT_W        = 16
) (
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              ireq,
  input  logic              ienb,
  output logic              ofin,
  output logic              oref_req,
  input  logic              iref_gnt,
  output logic              oref_busy,
  output logic              oref_ovf,
  output wire logic         DRAM_CLK,
  output wire logic         DRAM_CKE,
  output wire logic         DRAM_CS_N,
  output wire logic         DRAM_RAS_N,
  output wire logic         DRAM_CAS_N,
  output wire logic         DRAM_WE_N,
  output wire logic         DRAM_LDQM,
  output wire logic         DRAM_UDQM,
  output wire logic [12:0]  DRAM_ADDR,
  output wire logic [1:0]   DRAM_BA,
  output wire logic [15:0]  DRAM_DQ
);

  // Wait states hold a timer loaded by the preceding one-cycle command state.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [CNT_W-1:0] N_REF    = CNT_W'(N_INIT_REF);
  localparam logic [CNT_W-1:0] IVL_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [12:0]      MODE     = mode_word(3'(CAS_LAT), 3'(BL_CODE), 1'(WB_SINGLE));

  state_t           state;
  logic [3:0]       cmd;
  logic [12:0]      addr;
  logic [1:0]       ba;
  logic             busy;
  logic [CNT_W-1:0] init_refs;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] ivl;
  logic [3:0]       pending;
  logic             ovf, ivl_run, expiry, ref_grant;

  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = '0;
    unique case (state)
      S_IDLE:           tmr_val = LD_PWRUP;
      S_PRE, S_A_PRE:   tmr_val = LD_RP;
      S_REF, S_A_REF:   tmr_val = LD_RFC;
      S_LOAD:           tmr_val = LD_MRD;
      default:          tmr_load = 1'b0;
    endcase
  end

  sdram_wait_timer #(.CNT_W(CNT_W)) u_dwell (
    .iclk(iclk), .ctr_reset(ctr_reset), .load(tmr_load), .load_val(tmr_val), .done(tmr_done)
  );

  // Refresh handshake: oref_req stays high while any refresh is pending; a grant
  // counts only in a cycle where oref_req=1 and the controller sits in READY.
  assign ivl_run   = state inside {S_READY, S_A_PRE, S_A_PRE_W, S_A_REF, S_A_REF_W};
  assign expiry    = ivl_run && (ivl == IVL_LAST);
  assign ref_grant = (state == S_READY) && (pending != '0) && iref_gnt;

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      ivl     <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      ivl <= (!ivl_run || expiry) ? '0 : ivl + 1'b1;
      unique case ({expiry, ref_grant})
        2'b10:   if (pending == PEND_MAX) ovf <= 1'b1;
                 else                     pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state     <= S_IDLE;
      cmd       <= CMD_NOP;
      addr      <= '0;
      ba        <= '0;
      ofin      <= 1'b0;
      busy      <= 1'b0;
      init_refs <= '0;
    end else begin
      cmd  <= CMD_NOP;
      addr <= '0;
      ba   <= '0;
      unique case (state)
        S_IDLE: begin
          init_refs <= '0;
          if (ireq) state <= S_PWRUP;
        end
        S_PWRUP:
          if (tmr_done) begin
            state <= S_PRE; cmd <= CMD_PALL; addr <= ADDR_A10; ba <= 2'b11;
          end
        S_PRE:
          if (T_RP > 1) state <= S_PRE_W;
          else begin state <= S_REF; cmd <= CMD_REF; init_refs <= init_refs + 1'b1; end
        S_PRE_W:
          if (tmr_done) begin state <= S_REF; cmd <= CMD_REF; init_refs <= init_refs + 1'b1; end
        S_REF, S_REF_W:
          if (state == S_REF && T_RFC > 1) state <= S_REF_W;
          else if (state == S_REF || tmr_done) begin
            if (init_refs < N_REF) begin
              state <= S_REF; cmd <= CMD_REF; init_refs <= init_refs + 1'b1;
            end else begin
              state <= S_LOAD; cmd <= CMD_MRS; addr <= MODE;
            end
          end
        S_LOAD:
          if (T_MRD > 1) state <= S_LOAD_W;
          else begin state <= S_READY; ofin <= 1'b1; end
        S_LOAD_W:
          if (tmr_done) begin state <= S_READY; ofin <= 1'b1; end
        S_READY:
          if (ref_grant) begin
            state <= S_A_PRE; cmd <= CMD_PALL; addr <= ADDR_A10; ba <= 2'b11; busy <= 1'b1;
          end
        S_A_PRE:
          if (T_RP > 1) state <= S_A_PRE_W;
          else begin state <= S_A_REF; cmd <= CMD_REF; end
        S_A_PRE_W:
          if (tmr_done) begin state <= S_A_REF; cmd <= CMD_REF; end
        S_A_REF:
          if (T_RFC > 1) state <= S_A_REF_W;
          else begin state <= S_READY; busy <= 1'b0; end
        S_A_REF_W:
          if (tmr_done) begin state <= S_READY; busy <= 1'b0; end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign oref_req  = (pending != '0);
  assign oref_busy = busy;
  assign oref_ovf  = ovf;

  // The FSM keeps running with the bus released; only the pins float.
  assign DRAM_CLK   = ienb ? ~iclk   : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1    : 1'bz;
  assign DRAM_CS_N  = ienb ? cmd[3]  : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd[2]  : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd[1]  : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd[0]  : 1'bz;
  assign DRAM_LDQM  = ienb ? 1'b0    : 1'bz;
  assign DRAM_UDQM  = ienb ? 1'b0    : 1'bz;
  assign DRAM_ADDR  = ienb ? addr    : 13'bz;
  assign DRAM_BA    = ienb ? ba      : 2'bz;
  assign DRAM_DQ    = ienb ? 16'h0000 : 16'bz;

endmodule
